// File: rtl/pixel_io_ctrl.sv
// Pixel stream endpoint: receives one frame into the frame buffer, starts the
// filter core, then streams the filtered frame back out at one pixel per clock.
module pixel_io_ctrl #(
  parameter int PIXEL_NUM = 16384,
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 24
) (
  input  logic              clk,
  input  logic              xrst,
  output logic              rcv_req,
  input  logic              rcv_ack,
  input  logic [DATA_W-1:0] pixel_in,
  input  logic              snd_req,
  output logic              snd_ack,
  output logic [DATA_W-1:0] pixel_out,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              proc_start,
  input  logic              proc_done
);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    PROC,
    WAIT_SND,
    PREFETCH,
    SEND
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXEL_NUM - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  state_e            state_q;
  logic [ADDR_W-1:0] wcnt_q;
  logic [ADDR_W-1:0] rcnt_q;
  logic              last_q;
  logic              rcv_req_q;
  logic              snd_ack_q;
  logic              proc_start_q;

  // NOTE: all state updates are non-blocking so every register sees pre-edge values.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q      <= IDLE;
      wcnt_q       <= '0;
      rcnt_q       <= '0;
      last_q       <= 1'b0;
      rcv_req_q    <= 1'b0;
      snd_ack_q    <= 1'b0;
      proc_start_q <= 1'b0;
    end else begin
      snd_ack_q    <= 1'b0;
      proc_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q   <= RECV;
          rcv_req_q <= 1'b1;
        end
        RECV: begin
          if (rcv_ack) begin
            if (wcnt_q == LAST_ADDR) begin
              wcnt_q       <= '0;
              state_q      <= PROC;
              rcv_req_q    <= 1'b0;
              proc_start_q <= 1'b1;
            end else begin
              wcnt_q <= wcnt_q + ONE;
            end
          end
        end
        PROC: begin
          if (proc_done) state_q <= WAIT_SND;
        end
        WAIT_SND: begin
          if (snd_req) state_q <= PREFETCH;
        end
        PREFETCH: begin
          state_q   <= SEND;
          snd_ack_q <= 1'b1;
          rcnt_q    <= (LAST_ADDR == '0) ? '0 : ONE;
          last_q    <= (LAST_ADDR == '0);
        end
        SEND: begin
          // The final pixel re-presents the last address so no read runs past the frame.
          if (last_q) begin
            state_q   <= RECV;
            rcv_req_q <= 1'b1;
            rcnt_q    <= '0;
            last_q    <= 1'b0;
          end else if (rcnt_q == LAST_ADDR) begin
            last_q <= 1'b1;
          end else begin
            rcnt_q <= rcnt_q + ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rcv_req    = rcv_req_q;
  assign snd_ack    = snd_ack_q;
  assign proc_start = proc_start_q;

  // Write strobe, address and data follow rcv_ack within the same cycle.
  assign mem_we    = (state_q == RECV) && rcv_ack;
  assign mem_wdata = pixel_in;
  assign mem_addr  = (state_q == SEND) ? rcnt_q : wcnt_q;
  assign pixel_out = (state_q == SEND) ? mem_rdata : '0;

endmodule

// File: tb/tb_pixel_io_ctrl.sv
// Bench for pixel_io_ctrl: 16-pixel frames, 1-cycle-read RAM, and a stub core
// that inverts the buffer and pulses proc_done 5 cycles after proc_start.
module tb_pixel_io_ctrl;

  localparam int PN = 16;
  localparam int AW = 4;
  localparam int DW = 24;

  logic          clk      = 1'b0;
  logic          xrst     = 1'b0;
  logic          rcv_ack  = 1'b0;
  logic [DW-1:0] pixel_in = '0;
  logic          snd_req  = 1'b0;
  logic          rcv_req, snd_ack, mem_we, proc_start, proc_done;
  logic [DW-1:0] pixel_out, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int n_tests = 0;
  int n_fail  = 0;

  pixel_io_ctrl #(.PIXEL_NUM(PN), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .xrst      (xrst),
    .rcv_req   (rcv_req),
    .rcv_ack   (rcv_ack),
    .pixel_in  (pixel_in),
    .snd_req   (snd_req),
    .snd_ack   (snd_ack),
    .pixel_out (pixel_out),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .proc_start(proc_start),
    .proc_done (proc_done)
  );

  always #5 clk = ~clk;

  // Environment: frame buffer with registered read, plus an inverting stub core.
  logic [DW-1:0] ram [PN];
  int            core_cnt = 0;
  assign proc_done = (core_cnt == 1);

  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (proc_done) begin
      for (int i = 0; i < PN; i++) ram[i] <= ram[i] ^ 24'hFFFFFF;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    if (proc_start) core_cnt <= 5;
    else if (core_cnt > 0) core_cnt <= core_cnt - 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: event times of each frame derived from the protocol rules.
  int            mc       = 0;
  int            acc      = 0;
  int            t_ps     = -1;
  int            t_wait   = -1;
  int            t_ack    = -1;
  bit            rx_on    = 1'b0;
  bit            rst_pend = 1'b1;
  logic [DW-1:0] frame [PN];

  initial forever begin
    @(posedge clk or negedge xrst);
    if (!xrst) begin
      rx_on = 1'b0; rst_pend = 1'b1; acc = 0;
      t_ps = -1; t_wait = -1; t_ack = -1;
    end else begin
      if (rx_on && rcv_ack) begin
        frame[AW'(acc)] = pixel_in;
        acc++;
        if (acc == PN) begin
          rx_on = 1'b0; acc = 0; t_ps = mc + 1;
        end
      end
      if (t_ps >= 0 && t_wait < 0 && mc >= t_ps && proc_done) t_wait = mc + 1;
      if (t_wait >= 0 && t_ack < 0 && mc >= t_wait && snd_req) t_ack = mc + 2;
      if (t_ack >= 0 && mc == t_ack + PN - 1) begin
        rx_on = 1'b1; t_ps = -1; t_wait = -1; t_ack = -1;
      end
      if (rst_pend) begin
        rx_on = 1'b1; rst_pend = 1'b0;
      end
      mc++;
    end
  end

  int n_we = 0, n_ps = 0, n_ack = 0, ps_cyc = 0;

  task automatic compare_cycle();
    bit            in_send;
    int            idx;
    logic [DW-1:0] e_pix;
    logic [AW-1:0] e_addr;
    logic          e_we;
    in_send = (t_ack >= 0) && (mc >= t_ack) && (mc <= t_ack + PN - 1);
    e_we    = xrst && rx_on && rcv_ack;
    e_pix   = in_send ? ~frame[AW'(mc - t_ack)] : '0;
    if (rx_on) begin
      e_addr = AW'(acc);
    end else if (in_send) begin
      idx = mc - t_ack + 1;
      if (idx > PN - 1) idx = PN - 1;
      e_addr = AW'(idx);
    end else begin
      e_addr = '0;
    end
    check("rcv_req", 32'(rcv_req), 32'(rx_on));
    check("proc_start", 32'(proc_start), 32'(t_ps == mc));
    check("snd_ack", 32'(snd_ack), 32'(t_ack == mc));
    check("pixel_out", 32'(pixel_out), 32'(e_pix));
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_addr", 32'(mem_addr), 32'(e_addr));
    if (e_we) check("mem_wdata", 32'(mem_wdata), 32'(pixel_in));
    if (mem_we) n_we++;
    if (proc_start) begin
      n_ps++; ps_cyc = mc;
    end
    if (snd_ack) n_ack++;
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      compare_cycle();
    end
  end

  // Drives one frame of PN accepted pixels; gaps follow the pattern 1,0,0,1,...
  task automatic drive_frame(input bit gaps, input logic [DW-1:0] base, input logic [DW-1:0] step);
    int k = 0;
    @(posedge clk); #1;
    for (int j = 0; j < 100 && k < PN; j++) begin
      if (!gaps || (j % 3) == 0) begin
        rcv_ack  = 1'b1;
        pixel_in = base + step * DW'(k);
        k++;
      end else begin
        rcv_ack  = 1'b0;
        pixel_in = DW'($urandom);
      end
      @(posedge clk); #1;
    end
    rcv_ack = 1'b0;
  endtask

  int ack_t = 0;

  task automatic wait_ack();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      if (snd_ack) begin
        ok = 1'b1; ack_t = mc;
      end
    end
    check("snd_ack_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_rx();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      if (rcv_req) ok = 1'b1;
    end
    check("rcv_req_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: still running at %0t, required $finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b_we, b_ps, b_ack;

    // Reset state and release.
    repeat (3) @(posedge clk);
    #1;
    check("rst_rcv_req", 32'(rcv_req), 32'd0);
    check("rst_pixel_out", 32'(pixel_out), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    xrst = 1'b1;
    #1 check("rcv_req_before_edge", 32'(rcv_req), 32'd0);
    @(posedge clk); #1;
    check("rcv_req_after_release", 32'(rcv_req), 32'd1);

    // Gapless frame, then snd_req raised while the core is still running.
    b_ps  = n_ps;
    b_ack = n_ack;
    drive_frame(1'b0, 24'h000000, 24'h010203);
    check("t2_rcv_req_low", 32'(rcv_req), 32'd0);
    check("t2_proc_start", 32'(proc_start), 32'd1);
    check("t2_ram5", 32'(ram[5]), 32'h050A0F);
    check("t2_ram15", 32'(ram[15]), 32'h0F1E2D);
    snd_req = 1'b1;
    wait_ack();
    check("t4_ack_latency", ack_t - ps_cyc, 8);
    check("t4_pix0", 32'(pixel_out), 32'hFFFFFF);
    @(negedge clk); #1;
    check("t4_pix1", 32'(pixel_out), 32'hFEFDFC);
    snd_req = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    check("t4_rcv_req_back", 32'(rcv_req), 32'd1);
    check("t4_pixel_idle", 32'(pixel_out), 32'd0);
    check("t4_one_proc_start", n_ps - b_ps, 1);
    check("t4_one_snd_ack", n_ack - b_ack, 1);

    // Gapped frame plus a stray 17th rcv_ack; snd_req raised late in WAIT_SND.
    b_we = n_we;
    drive_frame(1'b1, 24'hA00000, 24'h000111);
    check("t3_ram15", 32'(ram[15]), 32'hA00FFF);
    rcv_ack = 1'b1;
    @(posedge clk); #1;
    rcv_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t3_write_count", n_we - b_we, 16);
    repeat (8) @(posedge clk);
    #1;
    snd_req = 1'b1;
    wait_ack();
    check("t3_ack_delay", ack_t - ps_cyc, 14);
    check("t3_pix0", 32'(pixel_out), 32'h5FFFFF);
    snd_req = 1'b0;
    wait_rx();

    // Reset in the middle of SEND, then a full frame end to end.
    drive_frame(1'b0, 24'h123456, 24'h000001);
    snd_req = 1'b1;
    wait_ack();
    repeat (7) @(posedge clk);
    #1;
    check("t5_pix7", 32'(pixel_out), 32'hEDCBA2);
    xrst    = 1'b0;
    snd_req = 1'b0;
    #1;
    check("t5_rst_rcv_req", 32'(rcv_req), 32'd0);
    check("t5_rst_snd_ack", 32'(snd_ack), 32'd0);
    check("t5_rst_pixel_out", 32'(pixel_out), 32'd0);
    check("t5_rst_mem_we", 32'(mem_we), 32'd0);
    check("t5_rst_mem_addr", 32'(mem_addr), 32'd0);
    check("t5_rst_proc_start", 32'(proc_start), 32'd0);
    repeat (2) @(posedge clk);
    #1 xrst = 1'b1;
    drive_frame(1'b0, 24'h0F0F0F, 24'h001000);
    snd_req = 1'b1;
    wait_ack();
    check("t5_new_pix0", 32'(pixel_out), 32'hF0F0F0);
    snd_req = 1'b0;
    wait_rx();

    // Two back-to-back frames with snd_req held high throughout.
    b_ack   = n_ack;
    snd_req = 1'b1;
    drive_frame(1'b0, 24'h111111, 24'h010101);
    wait_ack();
    check("t6_f1_pix0", 32'(pixel_out), 32'hEEEEEE);
    wait_rx();
    drive_frame(1'b0, 24'h800000, 24'h000F00);
    wait_ack();
    check("t6_f2_pix0", 32'(pixel_out), 32'h7FFFFF);
    @(negedge clk); #1;
    check("t6_f2_pix1", 32'(pixel_out), 32'h7FF0FF);
    wait_rx();
    check("t6_ack_count", n_ack - b_ack, 2);
    snd_req = 1'b0;
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
